// File: rtl/pc_fetch_reg.sv
// Program-counter register stage behind muxPC. It holds the fetch address under a
// valid/ready handshake and keeps a branch target that resolves during a fetch stall.
module pc_fetch_reg #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               INC      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] muxPCOut,
   input  logic             PCSRC,
   input  logic             fetch_ready,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PCAdderAddr,
   output logic             fetch_valid,
   output logic             br_pending
);

   localparam logic [1:0] S_BOOT    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_WAIT_BR = 2'd3;

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] br_buf_q, br_buf_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      br_buf_d = br_buf_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (fetch_ready) begin
               pc_d = muxPCOut;
            end else if (PCSRC) begin
               br_buf_d = muxPCOut;
               state_d  = S_WAIT_BR;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fetch_ready) begin
               pc_d    = muxPCOut;
               state_d = S_FETCH;
            end else if (PCSRC) begin
               br_buf_d = muxPCOut;
               state_d  = S_WAIT_BR;
            end
         end
         S_WAIT_BR: begin
            // A branch resolving in the release cycle is younger than the buffered one.
            if (fetch_ready) begin
               pc_d    = PCSRC ? muxPCOut : br_buf_q;
               state_d = S_FETCH;
            end else if (PCSRC) begin
               br_buf_d = muxPCOut;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         br_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         br_buf_q <= br_buf_d;
      end
   end

   assign PC          = pc_q;
   assign PCAdderAddr = pc_q + INC_W;
   assign fetch_valid = (state_q != S_BOOT);
   assign br_pending  = (state_q == S_WAIT_BR);

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed bench for pc_fetch_reg: each step queues the expected post-edge outputs,
// then pops and checks them one cycle later.
module tb_pc_fetch_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] muxPCOut;
   logic       PCSRC;
   logic       fetch_ready;
   logic [7:0] PC;
   logic [7:0] PCAdderAddr;
   logic       fetch_valid;
   logic       br_pending;

   typedef struct packed {
      logic [7:0] pc;
      logic       valid;
      logic       pend;
   } exp_t;

   exp_t q[$];
   int   tests_run = 0;
   int   fails     = 0;
   int   step_no   = 0;

   pc_fetch_reg #(.WIDTH(8), .RESET_PC(8'h00), .INC(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .muxPCOut    (muxPCOut),
      .PCSRC       (PCSRC),
      .fetch_ready (fetch_ready),
      .PC          (PC),
      .PCAdderAddr (PCAdderAddr),
      .fetch_valid (fetch_valid),
      .br_pending  (br_pending)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [7:0] mux, input logic src, input logic rdy,
                       input logic [7:0] e_pc, input logic e_v, input logic e_p);
      exp_t e;
      exp_t got;
      logic [7:0] e_add;
      rst_n = r; muxPCOut = mux; PCSRC = src; fetch_ready = rdy;
      e.pc = e_pc; e.valid = e_v; e.pend = e_p;
      q.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      got   = q.pop_front();
      e_add = got.pc + 8'd1;
      tests_run += 4;
      assert (PC === got.pc) else begin
         fails++;
         $error("FAIL pc step %0d: got %h expected %h", step_no, PC, got.pc);
      end
      assert (PCAdderAddr === e_add) else begin
         fails++;
         $error("FAIL adder step %0d: got %h expected %h", step_no, PCAdderAddr, e_add);
      end
      assert (fetch_valid === got.valid) else begin
         fails++;
         $error("FAIL valid step %0d: got %b expected %b", step_no, fetch_valid, got.valid);
      end
      assert (br_pending === got.pend) else begin
         fails++;
         $error("FAIL pend step %0d: got %b expected %b", step_no, br_pending, got.pend);
      end
      $display("[TB] step %0d rst_n=%b mux=%h src=%b rdy=%b -> PC=%h add=%h v=%b p=%b",
               step_no, r, mux, src, rdy, PC, PCAdderAddr, fetch_valid, br_pending);
   endtask

   initial begin
      rst_n = 1'b0; muxPCOut = 8'h00; PCSRC = 1'b0; fetch_ready = 1'b0;
      // reset for two clocks, then boot cycle
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      // sequential fetch, one PC per clock
      step(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
      step(1'b1, 8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
      step(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
      // stall without branch: PC held, mux ignored
      step(1'b1, 8'h06, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      step(1'b1, 8'h06, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0);
      // taken branch on transfer
      step(1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
      // branch captured during stall, released from buffer
      step(1'b1, 8'hF0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1);
      step(1'b1, 8'h11, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
      // same-cycle branch beats buffered target
      step(1'b1, 8'hF0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b1);
      step(1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
      // newer branch while stalled overwrites buffer
      step(1'b1, 8'hF0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
      step(1'b1, 8'hA0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
      step(1'b1, 8'h55, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1);
      step(1'b1, 8'h12, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0);
      // plain stall then branch capture
      step(1'b1, 8'h21, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b1);
      step(1'b1, 8'h99, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      // wrap at FF
      step(1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      // reset while a branch is pending
      step(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h34, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h35, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h36, 1'b0, 1'b1, 8'h36, 1'b1, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
